uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter STOP_TICKS, default 16, the number of brg_tick periods the stop bit lasts; legal values are 16 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port brg_tick, input, 1 bit: a one-clk pulse at 16x the bit rate, from the same BRG that feeds uart_rx.
REQ-005 SHALL have port d, input, 8 bits: the byte to transmit, sampled when tx_wr_tick=1.
REQ-006 SHALL have port tx_wr_tick, input, 1 bit: a one-clk write strobe into the holding register.
REQ-007 SHALL have port tx_ready, output, 1 bit: 1 while the holding register is empty and can accept a write.
REQ-008 SHALL have port tx_done_tick, output, 1 bit: a one-clk pulse when a frame's stop bit completes.
REQ-009 SHALL have port tx, output, 1 bit: the registered serial line, idle high (marking); it directly drives uart_rx.rx.

Function
REQ-010 SHALL double-buffer data with a holding register (THR) and a shift register (TSR); tx_ready SHALL equal the registered value of NOT thr_full.
REQ-011 SHALL load d into the THR and set thr_full on any clk where tx_wr_tick=1 and tx_ready=1, so tx_ready reads 0 on the next clk.
REQ-012 SHALL discard a tx_wr_tick that arrives while tx_ready=0, leaving the THR, TSR and frame in progress unchanged.
REQ-013 SHALL use one-hot FSM states IDLE, START, DATA and STOP, a 5-bit tick counter and a 3-bit bit counter, with all counters advancing only on clks where brg_tick=1.
REQ-014 IDLE: on a clk where brg_tick=1 and thr_full=1, SHALL copy THR to TSR, clear thr_full, zero the tick counter and enter START; tx SHALL be 0 from the next clk.
REQ-015 START: SHALL hold tx=0 for 16 brg_ticks, then enter DATA with tx=TSR[0] and the bit counter at 0.
REQ-016 DATA: SHALL hold each bit for 16 brg_ticks, then shift the TSR right and increment the bit counter; after bit 7 completes, SHALL enter STOP with tx=1.
REQ-017 SHALL transmit data LSB first, with 8 data bits, no parity, and no inversion.
REQ-018 STOP: SHALL hold tx=1 for STOP_TICKS brg_ticks and pulse tx_done_tick on the final tick.
REQ-019 At the end of STOP, if thr_full=1, SHALL perform the REQ-014 transfer in the same clk and enter START, so frames go back-to-back with no idle gap; otherwise SHALL enter IDLE.
REQ-020 SHALL give the transfer precedence when it coincides with a tx_wr_tick: tx_ready is 0 in that clk, so the write is ignored per REQ-012.
REQ-021 SHALL freeze tx, the FSM and the counters when brg_tick=0 on every clk; writes to an empty THR SHALL still be accepted.
REQ-022 SHALL make every frame last exactly 16*9+STOP_TICKS brg_ticks from the first tx=0 to the end of the stop bit.
REQ-023 SHALL drive tx from a flop only, so it carries no combinational glitches.

Reset
REQ-024 While reset=1, regardless of clk, SHALL force state=IDLE, tx=1, tx_ready=1, tx_done_tick=0, thr_full=0, and all counters and the TSR to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame, return tx to 1 immediately, and discard the THR contents.
REQ-026 After reset releases, SHALL accept the first tx_wr_tick on the first clk.

Verification
REQ-027 Write d=0x35 once: tx SHALL be start 0, then 1,0,1,0,1,1,0,0, then stop 1, at 16 ticks per bit; tx_done_tick SHALL pulse once; looped into uart_rx, d SHALL read 0x35 with no frame error.
REQ-028 Write 0x35, then write 0xFF as soon as tx_ready=1: the 0xFF start bit SHALL begin on the brg_tick that ends the first stop bit, and uart_rx SHALL receive 0x35 then 0xFF.
REQ-029 Write 0xA5 while tx_ready=0 during a frame of 0x35: the 0xA5 write SHALL be ignored, and only 0x35 plus any previously held byte SHALL appear on tx.
REQ-030 Assert reset during DATA bit 3: tx SHALL equal 1 asynchronously, tx_ready SHALL be 1, and no tx_done_tick SHALL occur.
REQ-031 Hold brg_tick=0 for 1000 clks mid-frame: tx SHALL stay constant; on resuming ticks, the frame SHALL complete with correct data.
REQ-032 With STOP_TICKS=32, send 0x00 twice back-to-back: the stop high time SHALL be 32 brg_ticks and the frame 176 brg_ticks.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with double buffering (holding register
// THR in front of shift register TSR), paced by a 16x bit-rate tick.
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   reset        asynchronous, active-high reset
//   brg_tick     one-clk pulse at 16x the bit rate; the FSM and counters
//                only advance on clks where it is 1
//   d[7:0]       byte to transmit, captured on an accepted write
//   tx_wr_tick   one-clk write strobe into the THR
//   tx_ready     1 while the THR is empty (registered NOT thr_full)
//   tx_done_tick one-clk pulse after the final tick of each stop bit
//   tx           registered serial line, idle high
//   dbg_state    one-hot FSM state {STOP, DATA, START, IDLE}
//
// Write handshake: tx_wr_tick acts as valid and tx_ready as ready. A byte is
// taken only on a clk where both are 1; a strobe while tx_ready=0 is dropped
// and nothing else changes. tx_ready falls on the clk after an accepted write.
module uart_tx #(
  parameter int STOP_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       brg_tick,
  input  logic [7:0] d,
  input  logic       tx_wr_tick,
  output logic       tx_ready,
  output logic       tx_done_tick,
  output logic       tx,
  output logic [3:0] dbg_state
);

  localparam logic [3:0] IDLE  = 4'b0001;
  localparam logic [3:0] START = 4'b0010;
  localparam logic [3:0] DATA  = 4'b0100;
  localparam logic [3:0] STOP  = 4'b1000;

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(STOP_TICKS - 1);

  logic [3:0] state;
  logic [4:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] thr;
  logic [7:0] tsr;
  logic       thr_full;

  logic wr_accept;
  logic xfer;
  logic thr_full_next;

  assign dbg_state = state;

  // A transfer THR->TSR happens from IDLE, or on the last stop tick so the
  // next frame starts with no idle gap. Because tx_ready is NOT thr_full, a
  // write and a transfer can never land in the same clk.
  always_comb begin
    wr_accept     = tx_wr_tick & tx_ready;
    xfer          = brg_tick & thr_full &
                    ((state == IDLE) | ((state == STOP) & (tick_cnt == STOP_LAST)));
    thr_full_next = thr_full;
    if (wr_accept) begin
      thr_full_next = 1'b1;
    end else if (xfer) begin
      thr_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= 5'd0;
      bit_cnt      <= 3'd0;
      thr          <= 8'd0;
      tsr          <= 8'd0;
      thr_full     <= 1'b0;
      tx_ready     <= 1'b1;
      tx_done_tick <= 1'b0;
      tx           <= 1'b1;
    end else begin
      thr_full     <= thr_full_next;
      tx_ready     <= ~thr_full_next;
      tx_done_tick <= 1'b0;
      if (wr_accept) begin
        thr <= d;
      end
      if (brg_tick) begin
        case (state)
          IDLE: begin
            if (thr_full) begin
              tsr      <= thr;
              tick_cnt <= 5'd0;
              state    <= START;
              tx       <= 1'b0;
            end
          end
          START: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= 5'd0;
              bit_cnt  <= 3'd0;
              state    <= DATA;
              tx       <= tsr[0];
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
          DATA: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= 5'd0;
              tsr      <= {1'b0, tsr[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                // tsr[1] becomes the LSB after this shift
                tx <= tsr[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
          STOP: begin
            if (tick_cnt == STOP_LAST) begin
              tx_done_tick <= 1'b1;
              tick_cnt     <= 5'd0;
              if (thr_full) begin
                tsr   <= thr;
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= 5'd0;
            tx       <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx. Two instances: u_dut16 with the
// default 16-tick stop bit and u_dut32 with a 32-tick stop bit. brg_tick is
// one clk in every four. Frames are checked bit by bit at mid-bit ticks,
// and frame/stop lengths are measured in brg_tick units.
module tb_uart_tx;

  // ---------------- clock / reset / shared stimulus ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       brg_tick;
  logic [7:0] d;
  logic       tx_wr16;
  logic       tx_wr32;
  logic       tick_en = 1'b0;
  int         div = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div      = (div + 1) % 4;
        brg_tick = (div == 0);
      end else begin
        brg_tick = 1'b0;
      end
    end
  end

  // ---------------- DUTs ----------------
  logic       tx_ready16, done16, tx16;
  logic       tx_ready32, done32, tx32;
  logic [3:0] state16, state32;

  uart_tx u_dut16 (
    .clk(clk), .reset(reset), .brg_tick(brg_tick), .d(d), .tx_wr_tick(tx_wr16),
    .tx_ready(tx_ready16), .tx_done_tick(done16), .tx(tx16), .dbg_state(state16)
  );

  uart_tx #(.STOP_TICKS(32)) u_dut32 (
    .clk(clk), .reset(reset), .brg_tick(brg_tick), .d(d), .tx_wr_tick(tx_wr32),
    .tx_ready(tx_ready32), .tx_done_tick(done32), .tx(tx32), .dbg_state(state32)
  );

  logic       sel = 1'b0;
  logic       tx_s, done_s, ready_s;
  logic [3:0] state_s;
  assign tx_s    = sel ? tx32 : tx16;
  assign done_s  = sel ? done32 : done16;
  assign ready_s = sel ? tx_ready32 : tx_ready16;
  assign state_s = sel ? state32 : state16;

  // ---------------- monitors ----------------
  int   tick_count = 0;
  int   start_tick = 0;
  int   done_cnt16 = 0;
  int   done_cnt32 = 0;
  logic last_tx = 1'b1;

  always @(posedge clk) begin
    if (brg_tick) tick_count <= tick_count + 1;
  end

  // Start of a frame: tx falls, or tx is already low on the clk of a done
  // pulse (back-to-back frame).
  always @(negedge clk) begin
    last_tx <= tx_s;
    if (tx_s == 1'b0 && (last_tx == 1'b1 || done_s == 1'b1)) start_tick <= tick_count;
    if (done16) done_cnt16 <= done_cnt16 + 1;
    if (done32) done_cnt32 <= done_cnt32 + 1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver / wait tasks ----------------
  task automatic wr_byte(input logic use32, input logic [7:0] val);
    @(negedge clk);
    d = val;
    if (use32) tx_wr32 = 1'b1;
    else tx_wr16 = 1'b1;
    @(negedge clk);
    tx_wr16 = 1'b0;
    tx_wr32 = 1'b0;
  endtask

  task automatic wait_low(output logic found);
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (tx_s == 1'b0) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_high(output logic found);
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (tx_s == 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output logic found);
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (done_s == 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output logic found);
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (ready_s == 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_tick(input int target, output logic found);
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (tick_count >= target) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic idle_watch(input int n, output int lows);
    int t0;
    t0   = tick_count;
    lows = 0;
    for (int k = 0; k < 8000 && tick_count < t0 + n; k++) begin
      @(negedge clk);
      if (tx_s == 1'b0) lows++;
    end
  endtask

  // Checks one whole frame carrying exp. freeze_at >= 0 stops brg_tick for
  // 1000 clks at that bit's centre and writes freeze_byte into the THR.
  task automatic capture_frame(input logic [7:0] exp, input int s, input int freeze_at,
                               input logic [7:0] freeze_byte, output int c0, output int t_end);
    logic       f;
    logic [9:0] bits;
    int         t_rise, changes;
    logic       tx_hold;
    logic [3:0] st_hold;
    bits   = {1'b1, exp, 1'b0};
    t_rise = 0;
    wait_low(f);
    chk("start_seen", 32'(f), 1);
    @(negedge clk);
    c0 = start_tick;
    for (int i = 0; i < 10; i++) begin
      wait_tick(c0 + 16 * i + 8, f);
      chk($sformatf("bit%0d_reached", i), 32'(f), 1);
      chk($sformatf("bit%0d", i), 32'(tx_s), 32'(bits[i]));
      if (i == freeze_at) begin
        tick_en = 1'b0;
        tx_hold = tx_s;
        st_hold = state_s;
        changes = 0;
        for (int k = 0; k < 1000; k++) begin
          @(negedge clk);
          if (tx_s !== tx_hold || state_s !== st_hold) changes++;
        end
        chk("freeze_changes", changes, 0);
        wr_byte(sel, freeze_byte);
        chk("freeze_wr_taken", 32'(ready_s), 0);
        tick_en = 1'b1;
      end
      if (i == 8 && exp[7] == 1'b0) begin
        wait_high(f);
        chk("stop_rise_seen", 32'(f), 1);
        t_rise = tick_count;
      end
    end
    wait_done(f);
    chk("done_seen", 32'(f), 1);
    t_end = tick_count;
    chk("frame_len", t_end - c0, 144 + s);
    if (exp[7] == 1'b0) chk("stop_len", t_end - t_rise, s);
    @(negedge clk);
    chk("done_width", 32'(done_s), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic f;
    int   c0a, ea, c0b, eb, lows, c0;
    reset    = 1'b1;
    brg_tick = 1'b0;
    d        = 8'h00;
    tx_wr16  = 1'b0;
    tx_wr32  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx", 32'(tx16), 1);
    chk("rst_ready", 32'(tx_ready16), 1);
    chk("rst_done", 32'(done16), 0);
    chk("rst_state", 32'(state16), 32'h1);
    chk("rst_tx32", 32'(tx32), 1);

    // First write on the first clk after release, ticks still off
    reset   = 1'b0;
    d       = 8'h35;
    tx_wr16 = 1'b1;
    @(negedge clk);
    tx_wr16 = 1'b0;
    chk("first_wr_ready", 32'(tx_ready16), 0);
    chk("first_wr_idle", 32'(state16), 32'h1);
    chk("first_wr_tx", 32'(tx16), 1);
    tick_en = 1'b1;
    capture_frame(8'h35, 16, -1, 8'h00, c0a, ea);
    chk("single_ready", 32'(tx_ready16), 1);
    chk("single_done_cnt", done_cnt16, 1);

    // Back-to-back 0x35 then 0xFF
    wr_byte(1'b0, 8'h35);
    wait_ready(f);
    chk("b2b_ready_back", 32'(f), 1);
    wr_byte(1'b0, 8'hFF);
    capture_frame(8'h35, 16, -1, 8'h00, c0a, ea);
    chk("b2b_tx_low", 32'(tx_s), 0);
    capture_frame(8'hFF, 16, -1, 8'h00, c0b, eb);
    chk("b2b_no_gap", c0b, ea);
    chk("b2b_done_cnt", done_cnt16, 3);

    // Write while full is dropped
    wr_byte(1'b0, 8'h35);
    wait_ready(f);
    chk("drop_ready_back", 32'(f), 1);
    wr_byte(1'b0, 8'h11);
    chk("drop_full", 32'(tx_ready16), 0);
    wr_byte(1'b0, 8'hA5);
    capture_frame(8'h35, 16, -1, 8'h00, c0a, ea);
    capture_frame(8'h11, 16, -1, 8'h00, c0b, eb);
    chk("drop_no_gap", c0b, ea);
    idle_watch(200, lows);
    chk("drop_no_third_frame", lows, 0);
    chk("drop_done_cnt", done_cnt16, 5);

    // Freeze mid-frame; a write into the empty THR still lands
    wr_byte(1'b0, 8'h5A);
    capture_frame(8'h5A, 16, 5, 8'hC3, c0a, ea);
    chk("freeze_tx_low", 32'(tx_s), 0);
    capture_frame(8'hC3, 16, -1, 8'h00, c0b, eb);
    chk("freeze_no_gap", c0b, ea);
    chk("freeze_done_cnt", done_cnt16, 7);

    // Reset during data bit 3 with a byte held in the THR
    wr_byte(1'b0, 8'h35);
    wait_ready(f);
    chk("rst_mid_ready_back", 32'(f), 1);
    wr_byte(1'b0, 8'h77);
    chk("rst_mid_held", 32'(tx_ready16), 0);
    wait_low(f);
    chk("rst_mid_start", 32'(f), 1);
    @(negedge clk);
    c0 = start_tick;
    wait_tick(c0 + 72, f);
    chk("rst_mid_reached", 32'(f), 1);
    chk("rst_mid_bit3", 32'(tx16), 0);
    reset = 1'b1;
    #1;
    chk("rst_async_tx", 32'(tx16), 1);
    chk("rst_async_ready", 32'(tx_ready16), 1);
    chk("rst_async_state", 32'(state16), 32'h1);
    chk("rst_async_done", 32'(done16), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_watch(400, lows);
    chk("rst_thr_discarded", lows, 0);
    chk("rst_no_done", done_cnt16, 7);
    chk("rst_ready_after", 32'(tx_ready16), 1);

    // STOP_TICKS=32: two 0x00 frames back-to-back
    sel = 1'b1;
    wr_byte(1'b1, 8'h00);
    wait_ready(f);
    chk("s32_ready_back", 32'(f), 1);
    wr_byte(1'b1, 8'h00);
    capture_frame(8'h00, 32, -1, 8'h00, c0a, ea);
    chk("s32_tx_low", 32'(tx_s), 0);
    capture_frame(8'h00, 32, -1, 8'h00, c0b, eb);
    chk("s32_no_gap", c0b, ea);
    chk("s32_done_cnt", done_cnt32, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
